// File: rtl/fp_exp_pkg.sv
// Shared definitions for the FP multiplier exponent update stage:
// FSM encoding, exponent upper limit and internal adder width.
package fp_exp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RND = 2'd1,
        OUT      = 2'd2
    } exp_state_e;

    // Largest finite biased exponent for a W-bit exponent field.
    function automatic int U_LIMIT(input int W);
        return (1 << W) - 2;
    endfunction

    // Two guard bits: one for sign, one for headroom above the Inf exponent.
    function automatic int unsigned exp_int_width(input int unsigned W);
        return W + 2;
    endfunction

endpackage

// File: rtl/exp_range_check.sv
// Classifies the final exponent as overflow/underflow/normal.
// Saturation of the exponent on out-of-range results is enabled by EXP_SAT_EN.
module exp_range_check
    import fp_exp_pkg::*;
#(
    parameter int unsigned W_Exp = 8
) (
    input  logic [W_Exp+1:0] i_e2,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic [W_Exp-1:0] o_exp
);

    localparam int unsigned W_INT = exp_int_width(W_Exp);
    localparam logic [W_INT-1:0] L_LIMIT = W_INT'(U_LIMIT(W_Exp));

    logic w_overflow;
    logic w_underflow;

    assign w_overflow  = $signed(i_e2) > $signed(L_LIMIT);
    assign w_underflow = i_e2[W_INT-1] | (i_e2 == '0);

    assign o_overflow  = w_overflow;
    assign o_underflow = w_underflow;

`ifdef EXP_SAT_EN
    always_comb begin
        o_exp = i_e2[W_Exp-1:0];
        if (w_overflow) begin
            o_exp = '1;
        end else if (w_underflow) begin
            o_exp = '0;
        end
    end
`else
    assign o_exp = i_e2[W_Exp-1:0];
`endif

endmodule

// File: rtl/exp_update_pipe.sv
// Exponent update stage: normalisation increment, wait for post-round carry,
// second increment and range classification. Optional saturation: EXP_SAT_EN.
module exp_update_pipe
    import fp_exp_pkg::*;
#(
    parameter int unsigned W_Exp = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [W_Exp+1:0] i_exp_pr,
    input  logic             i_exp_na,
    input  logic             i_rnd_valid,
    input  logic             i_rnd_carry,
    output logic             o_rnd_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [W_Exp-1:0] o_exp_act,
    output logic             o_overflow_b,
    output logic             o_underflow_b
);

    localparam int unsigned W_INT = exp_int_width(W_Exp);

    exp_state_e       r_state;
    logic [W_INT-1:0] r_e1;
    logic [W_Exp-1:0] r_exp_act;
    logic             r_overflow;
    logic             r_underflow;

    logic [W_INT-1:0] w_e1_next;
    logic [W_INT-1:0] w_e2;
    logic             w_overflow;
    logic             w_underflow;
    logic [W_Exp-1:0] w_exp_sat;

    assign w_e1_next = i_exp_pr + {{(W_INT-1){1'b0}}, i_exp_na};
    assign w_e2      = r_e1 + {{(W_INT-1){1'b0}}, i_rnd_carry};

    exp_range_check #(
        .W_Exp (W_Exp)
    ) u_range_check (
        .i_e2        (w_e2),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow),
        .o_exp       (w_exp_sat)
    );

    // in_ready is held low while reset is asserted even though the state reads IDLE.
    assign o_in_ready  = i_rst_n & ((r_state == IDLE) | ((r_state == OUT) & i_out_ready));
    assign o_rnd_ready = (r_state == WAIT_RND);
    assign o_out_valid = (r_state == OUT);

    assign o_exp_act     = r_exp_act;
    assign o_overflow_b  = r_overflow;
    assign o_underflow_b = r_underflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_e1        <= '0;
            r_exp_act   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_state     <= IDLE;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_e1    <= w_e1_next;
                        r_state <= WAIT_RND;
                    end
                end
                WAIT_RND: begin
                    if (i_rnd_valid) begin
                        r_exp_act   <= w_exp_sat;
                        r_overflow  <= w_overflow;
                        r_underflow <= w_underflow;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (i_out_ready) begin
                        if (i_in_valid) begin
                            r_e1    <= w_e1_next;
                            r_state <= WAIT_RND;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_update_pipe.sv
// Directed self-checking bench for exp_update_pipe at W_Exp=8.
// Expected exponents follow EXP_SAT_EN when it is defined for the build.
module tb_exp_update_pipe;

    localparam int unsigned W = 8;

`ifdef EXP_SAT_EN
    localparam logic [31:0] EXP_UNF_M1 = 32'h00;
`else
    localparam logic [31:0] EXP_UNF_M1 = 32'hFF;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W+1:0] exp_pr    = '0;
    logic         exp_na    = 1'b0;
    logic         rnd_valid = 1'b0;
    logic         rnd_carry = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         rnd_ready;
    logic         out_valid;
    logic [W-1:0] exp_act;
    logic         ovf;
    logic         unf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exp_update_pipe #(
        .W_Exp (W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_exp_pr      (exp_pr),
        .i_exp_na      (exp_na),
        .i_rnd_valid   (rnd_valid),
        .i_rnd_carry   (rnd_carry),
        .o_rnd_ready   (rnd_ready),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_exp_act     (exp_act),
        .o_overflow_b  (ovf),
        .o_underflow_b (unf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int pr, input logic na);
        int v;
        v        = pr;
        in_valid = 1'b1;
        exp_pr   = v[W+1:0];
        exp_na   = na;
        step();
        in_valid = 1'b0;
        exp_pr   = '0;
        exp_na   = 1'b0;
    endtask

    task automatic round(input logic c);
        rnd_valid = 1'b1;
        rnd_carry = c;
        step();
        rnd_valid = 1'b0;
        rnd_carry = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] e, input logic ov, input logic un);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".exp_act"}, 32'(exp_act), e);
        chk({tag, ".overflow"}, 32'(ovf), 32'(ov));
        chk({tag, ".underflow"}, 32'(unf), 32'(un));
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.rnd_ready", 32'(rnd_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.exp_act", 32'(exp_act), 32'd0);
        chk("rst.flags", 32'({ovf, unf}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle.in_ready", 32'(in_ready), 32'd1);

        // Normal path: 100 + 1 + 0, rnd_valid ignored in IDLE.
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        chk("idle_rnd.rnd_ready", 32'(rnd_ready), 32'd0);
        load(100, 1'b1);
        chk("norm.rnd_ready", 32'(rnd_ready), 32'd1);
        chk("norm.in_ready", 32'(in_ready), 32'd0);
        chk("norm.no_out", 32'(out_valid), 32'd0);
        round(1'b0);
        result("norm", 32'd101, 1'b0, 1'b0);
        pop();
        chk("norm.popped", 32'(out_valid), 32'd0);
        chk("norm.idle_ready", 32'(in_ready), 32'd1);

        // Overflow boundary: 254 is normal, 255 overflows.
        load(253, 1'b1);
        round(1'b0);
        result("lim254", 32'd254, 1'b0, 1'b0);
        pop();
        load(253, 1'b1);
        round(1'b1);
        result("ovf255", 32'd255, 1'b1, 1'b0);
        pop();

        // Underflow boundary: 1 is normal, 0 and -1 underflow.
        load(0, 1'b1);
        round(1'b0);
        result("lim1", 32'd1, 1'b0, 1'b0);
        pop();
        load(-1, 1'b1);
        round(1'b0);
        result("unf0", 32'd0, 1'b0, 1'b1);
        pop();
        load(-3, 1'b1);
        round(1'b1);
        result("unfm1", EXP_UNF_M1, 1'b0, 1'b1);
        pop();

        // Back-pressure, then back-to-back accept in the same cycle as out_ready.
        load(50, 1'b0);
        round(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.exp_act", 32'(exp_act), 32'd50);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        exp_pr    = 10'd10;
        exp_na    = 1'b0;
        #1;
        chk("b2b.in_ready", 32'(in_ready), 32'd1);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_pr    = '0;
        chk("b2b.rnd_ready", 32'(rnd_ready), 32'd1);
        chk("b2b.out_valid", 32'(out_valid), 32'd0);
        round(1'b0);
        result("b2b", 32'd10, 1'b0, 1'b0);
        pop();

        // Delayed rounding with a stray input pulse while waiting.
        load(20, 1'b1);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i == 2);
            exp_pr   = 10'd99;
            step();
            chk("dly.wait", 32'({out_valid, rnd_ready}), 32'b01);
        end
        in_valid = 1'b0;
        exp_pr   = '0;
        round(1'b1);
        result("dly", 32'd22, 1'b0, 1'b0);
        pop();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dly.single", 32'({out_valid, rnd_ready}), 32'b00);
        end

        // Flush in WAIT_RND and in OUT.
        load(30, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flw.state", 32'({in_ready, rnd_ready, out_valid}), 32'b100);
        load(253, 1'b1);
        round(1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flo.out_valid", 32'(out_valid), 32'd0);
        chk("flo.flags", 32'({ovf, unf}), 32'd0);
        chk("flo.in_ready", 32'(in_ready), 32'd1);

        // Reset mid-operation acts immediately and emits nothing afterwards.
        load(253, 1'b1);
        round(1'b1);
        rnd_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("arst.in_ready", 32'(in_ready), 32'd0);
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.exp_act", 32'(exp_act), 32'd0);
        chk("arst.flags", 32'({ovf, unf}), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst.quiet", 32'({out_valid, rnd_ready}), 32'b00);
        end
        rnd_valid = 1'b0;

        // Recovery after reset.
        load(127, 1'b0);
        round(1'b1);
        result("post", 32'd128, 1'b0, 1'b0);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exp_update_pipe.md
# exp_update_pipe

Parametrised exponent update stage for the floating-point multiplier datapath. It accepts a signed partial exponent from the exponent adder and applies the normalisation increment. It then waits for the rounding unit's post-round carry, applies the second increment, and classifies the result as overflow, underflow or normal. Valid/ready handshakes on input, rounding feedback and output let it sit between the exponent phase and the packing phase without lock-step control from the top-level FSM.

## Interface
- W_Exp, 8, width of the stored biased exponent; any value 4..15 (8 = single, 11 = double)
- clk  input  1  clock; one clock, all state on rising edge
- rst  input  1  reset; asynchronous and active-low
- flush  input  1  synchronous abort; returns to IDLE, drops any held operation
- in_valid  input  1  partial exponent offered
- in_ready  output  1  block can accept in_valid this cycle
- exp_pr  input  W_Exp+2  signed two's-complement biased partial exponent
- exp_na  input  1  normalisation increment required, sampled with exp_pr
- rnd_valid  input  1  rounding result offered
- rnd_carry  input  1  post-round mantissa overflow; increment required, sampled with rnd_valid
- rnd_ready  output  1  block can accept rnd_valid this cycle
- out_valid  output  1  exp_act and flags valid
- out_ready  input  1  downstream accepts result
- exp_act  output  W_Exp  final biased exponent
- overflow_b  output  1  final exponent > 2^W_Exp - 2
- underflow_b  output  1  final exponent <= 0

## Operation
- States: IDLE, WAIT_RND, OUT. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, register e1 = exp_pr + exp_na at W_Exp+2 bits signed, then go to WAIT_RND.
  - rnd_valid is ignored.
- WAIT_RND:
  - rnd_ready=1.
  - On rnd_valid, compute e2 = e1 + rnd_carry and register exp_act and the flags, then go to OUT.
  - in_valid is ignored.
- OUT:
  - out_valid=1; outputs stay stable until out_ready.
  - On out_ready, in_ready is also high in the same cycle. If in_valid is also high, load a new e1 and go to WAIT_RND; otherwise go to IDLE.
- Classification of e2:
  - overflow_b = (e2 >= 2^W_Exp - 1).
  - underflow_b = (e2 <= 0), signed compare.
  - Otherwise both flags are 0. The two flags are never both 1.
- Internal adders are W_Exp+2 bits wide and cannot wrap for any legal exp_pr in -(2^W_Exp)..(2^W_Exp + 1).
- flush overrides every other input in every state: next state IDLE, out_valid=0, flags cleared.
- Reset values: in_ready=0 while rst is low and 1 after release (IDLE); rnd_ready=0; out_valid=0; exp_act=0; overflow_b=0; underflow_b=0.

## Timing
- Input accepted in cycle n: rnd_ready is high from n+1.
- Rounding result accepted in cycle m (m >= n+1): out_valid is high from m+1.
- Minimum latency from input to output is 2 cycles. Sustained throughput is one operation per 2 cycles when rounding returns immediately and out_ready is held high.
- Handshake outputs (in_ready, rnd_ready, out_valid) are decoded from the state register only. in_ready additionally depends combinationally on out_ready in OUT.
- No input is ever dropped while its ready is high. The data inputs (exp_pr/exp_na, rnd_carry) are don't-care when their valid is low.

## Configuration
- EXP_SAT_EN defined:
  - On overflow, exp_act = 2^W_Exp - 1 (all ones, Inf exponent).
  - On underflow, exp_act = 0.
  - Otherwise exp_act = e2[W_Exp-1:0].
- EXP_SAT_EN undefined: exp_act = e2[W_Exp-1:0] unconditionally; the flags still report.

## Structure
- Shared package fp_exp_pkg holds:
  - state encodings IDLE=2'd0, WAIT_RND=2'd1, OUT=2'd2;
  - the upper-limit constant function U_LIMIT(W) = 2^W - 2;
  - the internal width constant W_Exp+2.
- One sub-module, exp_range_check: combinational, W_Exp parameter. It takes e2 and produces overflow, underflow and the saturated exponent. It is instantiated once.

## Test plan
W_Exp=8 for all scenarios.
- Normal path: exp_pr=100, exp_na=1, then rnd_carry=0 one cycle later -> out_valid at cycle 2, exp_act=101, both flags 0.
- Double increment to overflow: exp_pr=253, exp_na=1, rnd_carry=1 -> e2=255, overflow_b=1, exp_act=255 with EXP_SAT_EN, 255 without.
- Underflow: exp_pr=-3, exp_na=1, rnd_carry=1 -> underflow_b=1. exp_act=0 with EXP_SAT_EN; 0xFF (e2=-1 truncated) without.
- Back-pressure and back-to-back:
  - hold out_ready=0 for 5 cycles -> exp_act stable, in_ready=0 throughout;
  - then assert out_ready with in_valid and exp_pr=10 -> the new operation is accepted in the same cycle and the state goes to WAIT_RND.
- Delayed rounding: rnd_valid arrives 7 cycles after the input, and in_valid is pulsed meanwhile -> the extra input is ignored and exactly one result is produced.
- Flush and reset:
  - flush in WAIT_RND and in OUT -> IDLE next cycle, out_valid=0;
  - rst asserted low mid-operation -> all outputs at their reset values immediately (asynchronously), no result emitted after release.
